// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes fetched instructions into control words carried through ID/EX/MEM/WB and
// owns the core hazard logic. Define CTRL_PIPE_PERF_EN to add saturating stall/flush counters.
module ctrl_pipe #(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 4,
  parameter int ALU_OP_W = 4
`ifdef CTRL_PIPE_PERF_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [INSTR_W-1:0]    if_instr,
  output logic                  if_ready,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [8+ALU_OP_W-1:0] ex_ctrl,
  output logic [8+ALU_OP_W-1:0] mem_ctrl,
  output logic [8+ALU_OP_W-1:0] wb_ctrl,
  output logic [REG_W-1:0]      ex_ra,
  output logic [REG_W-1:0]      ex_rb,
  output logic [REG_W-1:0]      ex_rd,
  output logic [REG_W-1:0]      mem_rd,
  output logic [REG_W-1:0]      wb_rd,
  output logic                  illegal
`ifdef CTRL_PIPE_PERF_EN
  , output logic [CNT_W-1:0]    perf_stall
  , output logic [CNT_W-1:0]    perf_flush
`endif
);

  localparam int CTRL_W  = 8 + ALU_OP_W;
  localparam int B_REGWR = CTRL_W - 1;
  localparam int B_MEMEN = CTRL_W - 2;
  localparam int B_MEMRW = CTRL_W - 3;
  localparam int B_BR    = ALU_OP_W;
  localparam int OP_LSB  = INSTR_W - OPCODE_W;
  localparam int RD_LSB  = OP_LSB - REG_W;
  localparam int RA_LSB  = RD_LSB - REG_W;
  localparam int RB_LSB  = RA_LSB - REG_W;

  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ORR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_NOR = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LSL = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_LSR = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_LDW = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_LDB = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_STW = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_STB = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_BST = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_BLT = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_MOV = OPCODE_W'(16);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_ORR = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_NOR = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_LSL = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_LSR = ALU_OP_W'(7);

  // Packed as {regWrEn, memEn, memRW, memByte, SEL_valB, SEL_wrData, SEL_destReg, is_branch, alu_op}
  function automatic logic [CTRL_W-1:0] decode(input logic [OPCODE_W-1:0] op);
    logic [7:0]          f;
    logic [ALU_OP_W-1:0] alu;
    f   = 8'b0000_0000;
    alu = ALU_ADD;
    case (op)
      OP_ADD: begin f = 8'b1000_0000; alu = ALU_ADD; end
      OP_SUB: begin f = 8'b1000_0000; alu = ALU_SUB; end
      OP_AND: begin f = 8'b1000_0000; alu = ALU_AND; end
      OP_ORR: begin f = 8'b1000_0000; alu = ALU_ORR; end
      OP_NOR: begin f = 8'b1000_0000; alu = ALU_NOR; end
      OP_XOR: begin f = 8'b1000_0000; alu = ALU_XOR; end
      OP_LSL: begin f = 8'b1000_0000; alu = ALU_LSL; end
      OP_LSR: begin f = 8'b1000_0000; alu = ALU_LSR; end
      OP_LDW: f = 8'b1100_1110;
      OP_LDB: f = 8'b1101_1110;
      OP_STW: f = 8'b0110_1000;
      OP_STB: f = 8'b0111_1000;
      OP_BNE: begin f = 8'b0000_0001; alu = ALU_XOR; end
      OP_BST: begin f = 8'b0000_0001; alu = ALU_XOR; end
      OP_BLT: begin f = 8'b0000_0001; alu = ALU_SUB; end
      OP_MOV: f = 8'b1000_0000;
      default: begin f = 8'b0000_0000; alu = ALU_ADD; end
    endcase
    return {f, alu};
  endfunction

  function automatic logic is_known(input logic [OPCODE_W-1:0] op);
    return op <= OP_MOV;
  endfunction

  function automatic logic uses_rb(input logic [OPCODE_W-1:0] op);
    return (op >= OP_ADD && op <= OP_LSR) || op == OP_STW || op == OP_STB ||
           op == OP_BNE || op == OP_BST || op == OP_BLT;
  endfunction

  logic                id_vld_q;
  logic [OPCODE_W-1:0] id_op_q;
  logic [REG_W-1:0]    id_rd_q, id_ra_q, id_rb_q;
  logic                ex_vld_q, mem_vld_q, wb_vld_q, ill_q;
  logic [CTRL_W-1:0]   ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
  logic [REG_W-1:0]    ex_rd_q, ex_ra_q, ex_rb_q, mem_rd_q, wb_rd_q;

  logic [CTRL_W-1:0]   ex_ctrl_d;
  logic [REG_W-1:0]    ex_rd_d, ex_ra_d, ex_rb_d;
  logic                ill_d;
  logic                mem_stall, flush, load_use, ra_hit, rb_hit, accept;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^if_instr[RB_LSB-1:0];

  assign mem_stall = mem_vld_q && mem_ctrl_q[B_MEMEN] && !mem_ready;
  assign flush     = ex_vld_q && ex_ctrl_q[B_BR] && branch_taken && !mem_stall;
  assign ra_hit    = (id_op_q != OP_NOP) && (id_ra_q == ex_rd_q);
  assign rb_hit    = uses_rb(id_op_q) && (id_rb_q == ex_rd_q);
  assign load_use  = ex_vld_q && ex_ctrl_q[B_MEMEN] && !ex_ctrl_q[B_MEMRW] && id_vld_q &&
                     (ra_hit || rb_hit) && !mem_stall && !flush;
  assign if_ready  = !rst && !mem_stall && !flush && !load_use;
  assign accept    = if_valid && if_ready;

  // ID -> EX: decode from the ID register; an empty ID produces a bubble
  always_comb begin
    ex_ctrl_d = '0;
    ex_rd_d   = '0;
    ex_ra_d   = '0;
    ex_rb_d   = '0;
    ill_d     = 1'b0;
    if (id_vld_q) begin
      ex_ctrl_d = decode(id_op_q);
      ex_rd_d   = id_rd_q;
      ex_ra_d   = id_ra_q;
      ex_rb_d   = id_rb_q;
      ill_d     = !is_known(id_op_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_vld_q  <= 1'b0;  id_op_q  <= '0;  id_rd_q <= '0;  id_ra_q <= '0;  id_rb_q <= '0;
      ex_vld_q  <= 1'b0;  ex_ctrl_q <= '0; ex_rd_q <= '0;  ex_ra_q <= '0;  ex_rb_q <= '0;
      mem_vld_q <= 1'b0;  mem_ctrl_q <= '0; mem_rd_q <= '0;
      wb_vld_q  <= 1'b0;  wb_ctrl_q <= '0; wb_rd_q <= '0;
      ill_q     <= 1'b0;
    end else if (mem_stall) begin
      wb_vld_q  <= 1'b0;
      wb_ctrl_q <= '0;
      wb_rd_q   <= '0;
      ill_q     <= 1'b0;
    end else begin
      wb_vld_q   <= mem_vld_q;
      wb_ctrl_q  <= mem_ctrl_q;
      wb_rd_q    <= mem_rd_q;
      mem_vld_q  <= ex_vld_q;
      mem_ctrl_q <= ex_ctrl_q;
      mem_rd_q   <= ex_rd_q;
      if (flush || load_use) begin
        ex_vld_q  <= 1'b0;  ex_ctrl_q <= '0;  ex_rd_q <= '0;  ex_ra_q <= '0;  ex_rb_q <= '0;
        ill_q     <= 1'b0;
      end else begin
        ex_vld_q  <= id_vld_q;
        ex_ctrl_q <= ex_ctrl_d;
        ex_rd_q   <= ex_rd_d;
        ex_ra_q   <= ex_ra_d;
        ex_rb_q   <= ex_rb_d;
        ill_q     <= ill_d;
      end
      if (flush) begin
        id_vld_q <= 1'b0;
      end else if (!load_use) begin
        id_vld_q <= accept;
        if (accept) begin
          id_op_q <= if_instr[OP_LSB +: OPCODE_W];
          id_rd_q <= if_instr[RD_LSB +: REG_W];
          id_ra_q <= if_instr[RA_LSB +: REG_W];
          id_rb_q <= if_instr[RB_LSB +: REG_W];
        end
      end
    end
  end

  assign ex_valid  = ex_vld_q;
  assign mem_valid = mem_vld_q;
  assign wb_valid  = wb_vld_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign ex_ra     = ex_ra_q;
  assign ex_rb     = ex_rb_q;
  assign mem_rd    = mem_rd_q;
  assign wb_rd     = wb_rd_q;
  assign illegal   = ill_q;

`ifdef CTRL_PIPE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (mem_stall || load_use) perf_stall_q <= sat_inc(perf_stall_q);
      if (flush)                 perf_flush_q <= sat_inc(perf_flush_q);
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

  // Register-field check only matters for parameter sets where the regWrEn bit exists
  logic unused_regwr_bit;
  assign unused_regwr_bit = ex_ctrl_q[B_REGWR];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized + directed bench for ctrl_pipe against an instruction-slot reference model.
module tb_ctrl_pipe;
  localparam int INSTR_W = 32, OPCODE_W = 5, REG_W = 4, ALU_OP_W = 4, CTRL_W = 12;
`ifdef CTRL_PIPE_PERF_EN
  localparam int CNT_W = 4;
`endif
  localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_ORR = 4, OP_NOR = 5,
                 OP_XOR = 6, OP_LSL = 7, OP_LSR = 8, OP_LDW = 9, OP_LDB = 10, OP_STW = 11,
                 OP_STB = 12, OP_BNE = 13, OP_BST = 14, OP_BLT = 15, OP_MOV = 16;
  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_AND = 2, ALU_ORR = 3, ALU_NOR = 4,
                 ALU_XOR = 5, ALU_LSL = 6, ALU_LSR = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, if_valid, if_ready, branch_taken, mem_ready;
  logic [INSTR_W-1:0] if_instr;
  logic              ex_valid, mem_valid, wb_valid, illegal;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_W-1:0]  ex_ra, ex_rb, ex_rd, mem_rd, wb_rd;
`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0]  perf_stall, perf_flush;
`endif

  ctrl_pipe #(
    .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .REG_W(REG_W), .ALU_OP_W(ALU_OP_W)
`ifdef CTRL_PIPE_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .illegal(illegal)
`ifdef CTRL_PIPE_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  typedef struct packed { logic v; logic [31:0] ins; } slot_t;
  slot_t m_id, m_ex, m_mem, m_wb;
  logic  m_ill;
  int    m_pst, m_pfl;
  int    n_pass = 0, n_chk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int opc(input logic [31:0] i); return int'(i[31:27]); endfunction
  function automatic int frd(input logic [31:0] i); return int'(i[26:23]); endfunction
  function automatic int fra(input logic [31:0] i); return int'(i[22:19]); endfunction
  function automatic int frb(input logic [31:0] i); return int'(i[18:15]); endfunction

  function automatic logic [31:0] mk(input int op, input int rd, input int ra, input int rb);
    return {5'(op), 4'(rd), 4'(ra), 4'(rb), 15'(0)};
  endfunction

  // Control word from the opcode table: {regWrEn,memEn,memRW,memByte,valB,wrData,destReg,br,alu}
  function automatic logic [11:0] ctrl_of(input int op);
    case (op)
      OP_ADD: return {8'b1000_0000, 4'(ALU_ADD)};
      OP_SUB: return {8'b1000_0000, 4'(ALU_SUB)};
      OP_AND: return {8'b1000_0000, 4'(ALU_AND)};
      OP_ORR: return {8'b1000_0000, 4'(ALU_ORR)};
      OP_NOR: return {8'b1000_0000, 4'(ALU_NOR)};
      OP_XOR: return {8'b1000_0000, 4'(ALU_XOR)};
      OP_LSL: return {8'b1000_0000, 4'(ALU_LSL)};
      OP_LSR: return {8'b1000_0000, 4'(ALU_LSR)};
      OP_LDW: return {8'b1100_1110, 4'(ALU_ADD)};
      OP_LDB: return {8'b1101_1110, 4'(ALU_ADD)};
      OP_STW: return {8'b0110_1000, 4'(ALU_ADD)};
      OP_STB: return {8'b0111_1000, 4'(ALU_ADD)};
      OP_BNE: return {8'b0000_0001, 4'(ALU_XOR)};
      OP_BST: return {8'b0000_0001, 4'(ALU_XOR)};
      OP_BLT: return {8'b0000_0001, 4'(ALU_SUB)};
      OP_MOV: return {8'b1000_0000, 4'(ALU_ADD)};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic is_load(input int op); return op inside {OP_LDW, OP_LDB}; endfunction
  function automatic logic is_mem(input int op);
    return op inside {OP_LDW, OP_LDB, OP_STW, OP_STB};
  endfunction
  function automatic logic is_br(input int op); return op inside {OP_BNE, OP_BST, OP_BLT}; endfunction
  function automatic logic uses_rb(input int op);
    return op inside {[OP_ADD:OP_LSR], OP_STW, OP_STB, OP_BNE, OP_BST, OP_BLT};
  endfunction
  function automatic int sat(input int v, input int maxv); return (v >= maxv) ? maxv : v + 1; endfunction

  slot_t empty_s;

  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic bt, input logic mr);
    logic ms, fl, lu, rdy, hit;
    @(negedge clk);
    rst = r; if_valid = v; if_instr = ins; branch_taken = bt; mem_ready = mr;
    ms  = m_mem.v && is_mem(opc(m_mem.ins)) && !mr;
    fl  = !ms && m_ex.v && is_br(opc(m_ex.ins)) && bt;
    hit = ((opc(m_id.ins) != OP_NOP) && fra(m_id.ins) == frd(m_ex.ins)) ||
          (uses_rb(opc(m_id.ins)) && frb(m_id.ins) == frd(m_ex.ins));
    lu  = !ms && !fl && m_ex.v && is_load(opc(m_ex.ins)) && m_id.v && hit;
    rdy = !r && !ms && !fl && !lu;
    #1 check("if_ready", 64'(if_ready), 64'(rdy));
    @(posedge clk);
    if (r) begin
      m_id = empty_s; m_ex = empty_s; m_mem = empty_s; m_wb = empty_s;
      m_ill = 1'b0; m_pst = 0; m_pfl = 0;
    end else begin
`ifdef CTRL_PIPE_PERF_EN
      if (ms || lu) m_pst = sat(m_pst, (1 << CNT_W) - 1);
      if (fl)       m_pfl = sat(m_pfl, (1 << CNT_W) - 1);
`endif
      m_ill = 1'b0;
      if (ms) begin
        m_wb = empty_s;
      end else begin
        m_wb = m_mem; m_mem = m_ex;
        if (fl || lu) m_ex = empty_s;
        else begin
          m_ill = m_id.v && (opc(m_id.ins) > OP_MOV);
          m_ex  = m_id;
        end
        if (fl) m_id = empty_s;
        else if (!lu) m_id = v ? '{v: 1'b1, ins: ins} : empty_s;
      end
    end
    #1;
    check("ex",  {ex_valid, ex_ctrl, ex_rd, ex_ra, ex_rb},
          {m_ex.v, m_ex.v ? ctrl_of(opc(m_ex.ins)) : 12'h0,
           m_ex.v ? 4'(frd(m_ex.ins)) : 4'h0, m_ex.v ? 4'(fra(m_ex.ins)) : 4'h0,
           m_ex.v ? 4'(frb(m_ex.ins)) : 4'h0});
    check("mem", {mem_valid, mem_ctrl, mem_rd},
          {m_mem.v, m_mem.v ? ctrl_of(opc(m_mem.ins)) : 12'h0, m_mem.v ? 4'(frd(m_mem.ins)) : 4'h0});
    check("wb",  {wb_valid, wb_ctrl, wb_rd},
          {m_wb.v, m_wb.v ? ctrl_of(opc(m_wb.ins)) : 12'h0, m_wb.v ? 4'(frd(m_wb.ins)) : 4'h0});
    check("illegal", 64'(illegal), 64'(m_ill));
`ifdef CTRL_PIPE_PERF_EN
    check("perf_stall", 64'(perf_stall), 64'(m_pst));
    check("perf_flush", 64'(perf_flush), 64'(m_pfl));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    int op;
    op = int'($urandom_range(0, 19));
    if (op > OP_MOV) op = (op == 19) ? 31 : int'($urandom_range(17, 31));
    return {5'(op), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 15'($urandom)};
  endfunction

  initial begin
    empty_s = '{v: 1'b0, ins: 32'h0};
    m_id = empty_s; m_ex = empty_s; m_mem = empty_s; m_wb = empty_s;
    m_ill = 1'b0; m_pst = 0; m_pfl = 0;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; branch_taken = 1'b0; mem_ready = 1'b1;

    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, mk(OP_ADD, 1, 2, 3), 1'b0, 1'b1);

    // Back-to-back ADD/SUB, no hazards
    step(1'b0, 1'b1, mk(OP_ADD, 1, 2, 3), 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_SUB, 4, 1, 2), 1'b0, 1'b1);
    idle(4);

    // Two load-use interlocks
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, mk(OP_LDW, 5, 2, 0), 1'b0, 1'b1);
      step(1'b0, 1'b1, mk(OP_ADD, 6, 5, 1), 1'b0, 1'b1);
      idle(4);
    end

    // Load waits three cycles in MEM with an ADD held in ID
    step(1'b0, 1'b1, mk(OP_LDW, 7, 0, 0), 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_ADD, 1, 2, 3), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, mk(OP_SUB, 2, 3, 1), 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(4);

    // Taken branch flushes the instruction in ID
    step(1'b0, 1'b1, mk(OP_BNE, 0, 1, 2), 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_ADD, 3, 4, 5), 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_ADD, 8, 9, 10), 1'b1, 1'b1);
    idle(4);
`ifdef CTRL_PIPE_PERF_EN
    check("perf_stall_total", 64'(perf_stall), 64'd5);
    check("perf_flush_total", 64'(perf_flush), 64'd1);
`endif

    // Taken branch held off by a memory wait
    step(1'b0, 1'b1, mk(OP_LDW, 7, 0, 0), 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_BNE, 0, 1, 2), 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_ADD, 3, 4, 5), 1'b0, 1'b1);
    step(1'b0, 1'b1, mk(OP_MOV, 6, 1, 0), 1'b1, 1'b0);
    step(1'b0, 1'b1, mk(OP_MOV, 6, 1, 0), 1'b1, 1'b0);
    step(1'b0, 1'b1, mk(OP_MOV, 6, 1, 0), 1'b1, 1'b1);
    idle(4);

    // Unknown opcode
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(4);

    // Randomized traffic with occasional mid-stream resets
    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0), rand_instr(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
